// File: rtl/ram_async_ctrl.sv
// ram_async_ctrl: valid/ready request -> async 8-bit RAM cycles (setup, writeOn pulse, hold / settle-then-sample), registered response with range error
module ram_async_ctrl #(
  parameter int DEPTH     = 11,
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic [7:0] ram_address,
  output logic [7:0] ram_data_in,
  output logic       ram_writeOn,
  input  logic [7:0] ram_data_out
);
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, RWAIT, RESP} state_t;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  localparam logic [3:0] WR_LD   = 4'(WR_CYCLES - 1);
  localparam logic [3:0] RD_LD   = 4'(RD_CYCLES - 1);
  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic       r_write;
  logic       w_acc, w_legal, w_done;
  assign req_ready = (r_state == IDLE) && !rst;
  assign w_acc     = req_valid && req_ready;
  assign w_legal   = {1'b0, req_addr} < DEPTH_W;
  assign w_done    = r_cnt == 4'd0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? (w_legal ? SETUP : RESP) : IDLE;
      SETUP:   w_next = r_write ? WRITE : RWAIT;
      WRITE:   w_next = w_done ? HOLD : WRITE;
      HOLD:    w_next = RESP;
      RWAIT:   w_next = w_done ? RESP : RWAIT;
      RESP:    w_next = resp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_write     <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      ram_writeOn <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      r_cnt       <= (r_state == SETUP) ? (r_write ? WR_LD : RD_LD) : (w_done ? r_cnt : r_cnt - 4'd1);
      ram_writeOn <= w_next == WRITE;
      resp_valid  <= w_next == RESP;
      if (w_acc) begin
        resp_err   <= !w_legal;
        resp_rdata <= '0;
      end
      if (w_acc && w_legal) begin
        ram_address <= req_addr;
        ram_data_in <= req_wdata;
        r_write     <= req_write;
      end
      if (r_state == RWAIT && w_done) resp_rdata <= ram_data_out;
    end
  end
endmodule

// File: tb/tb_ram_async_ctrl.sv
// tb_ram_async_ctrl: scoreboard bench for ram_async_ctrl at default timing (inst 0) and WR=3/RD=4 (inst 1)
module tb_ram_async_ctrl;
  typedef struct {
    int         inst;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;
  localparam int WRN [2] = '{1, 3};
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid [2], req_ready [2], req_write [2], resp_valid [2], resp_ready [2], resp_err [2], ram_we [2];
  logic [7:0] req_addr [2], req_wdata [2], resp_rdata [2], ram_addr [2], ram_din [2], ram_dout [2];
  exp_t       sbq [$];
  int         cyc = 0, ntest = 0, nfail = 0;
  int         first [2], wcnt [2], hs_cyc [2];
  logic       seen [2], wprev [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [11];
    ram_async_ctrl #(.DEPTH(11), .WR_CYCLES(g ? 3 : 1), .RD_CYCLES(g ? 4 : 1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]), .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]),
      .ram_address(ram_addr[g]), .ram_data_in(ram_din[g]), .ram_writeOn(ram_we[g]), .ram_data_out(ram_dout[g])
    );
    always @* if (ram_we[g] && ram_addr[g] < 8'd11) mem[ram_addr[g]] = ram_din[g];
    assign ram_dout[g] = (ram_addr[g] < 8'd11) ? mem[ram_addr[g]] : 8'h00;
  end
  task automatic chk(input string nm, input int act, input int exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        seen[i]  = 1'b0;
        wcnt[i]  = 0;
        wprev[i] = 1'b0;
      end else begin
        if (resp_valid[i] && !seen[i]) begin
          seen[i]  = 1'b1;
          first[i] = cyc;
        end
        if (ram_we[i]) begin
          wcnt[i]++;
          if (sbq.size() == 0 || !sbq[0].wr || sbq[0].err) chk("spurious_writeOn", 1, 0);
          else begin
            chk("we_addr", ram_addr[i], sbq[0].addr);
            chk("we_data", ram_din[i], sbq[0].wdata);
          end
        end
        if (!ram_we[i] && wprev[i]) begin
          chk("we_width", wcnt[i], WRN[i]);
          if (sbq.size() > 0) begin
            chk("hold_addr", ram_addr[i], sbq[0].addr);
            chk("hold_data", ram_din[i], sbq[0].wdata);
          end
          wcnt[i] = 0;
        end
        wprev[i] = ram_we[i];
        if (resp_valid[i] && resp_ready[i]) begin
          if (sbq.size() == 0) chk("unexpected_resp", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("resp_inst", i, e.inst);
            chk("resp_rdata", resp_rdata[i], e.rdata);
            chk("resp_err", resp_err[i], e.err);
            chk("resp_latency", first[i] - e.acc, e.lat);
          end
          seen[i]   = 1'b0;
          hs_cyc[i] = cyc + 1;
        end
      end
    end
  end
  // lat = edges after the accept edge until resp_valid is seen; an error answers on the accept edge itself (0)
  task automatic issue(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rd, input logic er, input int lat, input bit stream);
    exp_t e;
    int   k = 0;
    @(negedge clk);
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_valid[i] = 1'b1;
    while (!req_ready[i] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      chk("accept_timeout", k, 0);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    e = '{inst: i, wr: w, addr: a, wdata: d, rdata: rd, err: er, lat: lat, acc: cyc};
    if (stream) chk("idle_gap", cyc - hs_cyc[i], 1);
    sbq.push_back(e);
  endtask
  task automatic drain();
    int k = 0;
    while (sbq.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() > 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(posedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; resp_ready[i] = 1'b1;
      hs_cyc[i] = 0; first[i] = 0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", req_ready[i], 0);
      chk("rst_resp_valid", resp_valid[i], 0);
      chk("rst_resp_err", resp_err[i], 0);
      chk("rst_resp_rdata", resp_rdata[i], 0);
      chk("rst_ram_addr", ram_addr[i], 0);
      chk("rst_ram_din", ram_din[i], 0);
      chk("rst_writeOn", ram_we[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", req_ready[0], 1);
    issue(0, 1'b1, 8'd3, 8'hA5, 8'h00, 1'b0, 3, 1'b0);
    drain();
    issue(0, 1'b0, 8'd3, 8'h00, 8'hA5, 1'b0, 2, 1'b0);
    drain();
    issue(0, 1'b1, 8'd10, 8'h11, 8'h00, 1'b0, 3, 1'b0);
    issue(0, 1'b1, 8'd0, 8'h22, 8'h00, 1'b0, 3, 1'b0);
    issue(0, 1'b0, 8'd10, 8'h00, 8'h11, 1'b0, 2, 1'b0);
    issue(0, 1'b0, 8'd0, 8'h00, 8'h22, 1'b0, 2, 1'b0);
    issue(0, 1'b1, 8'd11, 8'h77, 8'h00, 1'b1, 0, 1'b0);
    drain();
    chk("mem10_after_err", g_dut[0].mem[10], 8'h11);
    chk("addr_kept_after_err", ram_addr[0], 0);
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 8'd0, 8'h00, 8'h22, 1'b0, 2, 1'b0);
    k = 0;
    while (!resp_valid[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_resp_seen", resp_valid[0], 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid[0], 1);
      chk("bp_rdata", resp_rdata[0], 8'h22);
      chk("bp_req_ready", req_ready[0], 0);
      if (c == 1) begin
        req_write[0] = 1'b1; req_addr[0] = 8'd1; req_wdata[0] = 8'h99; req_valid[0] = 1'b1;
      end
      if (c == 2) req_valid[0] = 1'b0;
    end
    resp_ready[0] = 1'b1;
    drain();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_no_extra_resp", resp_valid[0], 0);
      chk("bp_back_idle", req_ready[0], 1);
    end
    issue(1, 1'b1, 8'd5, 8'h5C, 8'h00, 1'b0, 5, 1'b0);
    drain();
    issue(1, 1'b0, 8'd5, 8'h00, 8'h5C, 1'b0, 5, 1'b0);
    drain();
    issue(1, 1'b1, 8'd6, 8'h66, 8'h00, 1'b0, 5, 1'b0);
    k = 0;
    while (!ram_we[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rstw_in_write", ram_we[1], 1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_writeOn_async", ram_we[1], 0);
    chk("rstw_resp_valid", resp_valid[1], 0);
    chk("rstw_req_ready_in_rst", req_ready[1], 0);
    sbq.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstw_ready_after", req_ready[1], 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rstw_no_resp", resp_valid[1], 0);
    end
    for (int a = 0; a < 8; a++) begin
      issue(0, 1'b1, 8'(a), 8'(8'h30 + a), 8'h00, 1'b0, 3, a > 0);
      issue(0, 1'b0, 8'(a), 8'h00, 8'(8'h30 + a), 1'b0, 2, 1'b1);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
